// File: rtl/sar_pkg.sv
// sar_pkg: state type and round-robin channel search shared by the SAR sequencer.
package sar_pkg;

    // Upper bound on channel count handled by next_ch().
    localparam int MAX_CH = 32;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONV,
        DONE
    } sar_state_t;

    // Lowest set bit of mask strictly above cur; wraps to the lowest set bit
    // overall. Passing cur = MAX_CH-1 yields the lowest enabled channel.
    function automatic int next_ch(input logic [MAX_CH-1:0] mask, input int cur);
        int   res;
        logic found;
        res   = cur;
        found = 1'b0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > cur)) begin
                res   = i;
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int i = MAX_CH - 1; i >= 0; i--) begin
                if (mask[i]) res = i;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// sar_bit_engine: successive-approximation trial register and bit index.
// load presets the MSB trial; each step resolves the current bit from the
// comparator and sets the next lower trial bit.
module sar_bit_engine
    import sar_pkg::*;
#(
    parameter int unsigned ADC_BIT = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               comp_out,
    output logic [ADC_BIT-1:0] code,
    output logic               last
);

    localparam int unsigned IDX_W = $clog2(ADC_BIT);

    logic [ADC_BIT-1:0] code_q, code_d;
    logic [IDX_W-1:0]   idx_q,  idx_d;

    // Next trial code and bit index.
    always_comb begin
        // NOTE: defaulting every output to its held value first keeps this block free of latches.
        code_d = code_q;
        idx_d  = idx_q;
        if (load) begin
            code_d              = '0;
            code_d[ADC_BIT-1]   = 1'b1;
            idx_d               = IDX_W'(ADC_BIT - 1);
        end else if (step) begin
            code_d[idx_q] = comp_out;
            if (idx_q != '0) begin
                code_d[idx_q - 1'b1] = 1'b1;
                idx_d                = idx_q - 1'b1;
            end
        end
    end

    // Trial register state, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            code_q <= '0;
            idx_q  <= '0;
        end else begin
            code_q <= code_d;
            idx_q  <= idx_d;
        end
    end

    assign code = code_q;
    assign last = (idx_q == '0);

endmodule

// File: rtl/sar_seq_ctrl.sv
// sar_seq_ctrl: SAR ADC sequencer. Scans the masked channels one-shot or
// continuously, holds the sample switch, runs the binary search through
// sar_bit_engine and emits one tagged result per channel.
// Optional averaging of 2**AVG_LOG2 conversions per channel: define SAR_AVG_EN.
module sar_seq_ctrl
    import sar_pkg::*;
#(
    parameter  int unsigned ADC_BIT    = 10,
    parameter  int unsigned NCH        = 4,
    parameter  int unsigned SAMPLE_CYC = 2,
    parameter  int unsigned AVG_LOG2   = 2,
    localparam int unsigned CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               cont,
    input  logic [NCH-1:0]     ch_mask,
    input  logic               comp_out,
    output logic               sample,
    output logic [CH_W-1:0]    ch_sel,
    output logic [ADC_BIT-1:0] dac_code,
    output logic               busy,
    output logic [ADC_BIT-1:0] dout,
    output logic [CH_W-1:0]    dout_ch,
    output logic               dout_valid
);

    localparam int unsigned SC_W = $clog2(SAMPLE_CYC + 1);
`ifdef SAR_AVG_EN
    localparam int unsigned AVG_PASSES = 1 << AVG_LOG2;
    localparam int unsigned ACC_W      = ADC_BIT + AVG_LOG2;
    localparam int unsigned PASS_W     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
`else
    // Averaging disabled: AVG_LOG2 has no effect on the datapath.
    localparam int unsigned AVG_PASSES = 1 + 0 * AVG_LOG2;
`endif

    sar_state_t         state_q;
    logic [NCH-1:0]     mask_q;
    logic [CH_W-1:0]    ch_sel_q;
    logic [SC_W-1:0]    samp_cnt_q;
    logic               sample_q, busy_q, dout_valid_q;
    logic [ADC_BIT-1:0] dout_q;
    logic [CH_W-1:0]    dout_ch_q;
`ifdef SAR_AVG_EN
    logic [ACC_W-1:0]   acc_q;
    logic [PASS_W-1:0]  pass_q;
    logic [ACC_W-1:0]   acc_sum;
`endif

    logic               samp_done, eng_load, eng_step, eng_last;
    logic [ADC_BIT-1:0] eng_code, final_code;
    logic [CH_W-1:0]    first_ch, nxt_ch;
    logic               more_ch;

    assign samp_done  = (samp_cnt_q == SC_W'(SAMPLE_CYC - 1));
    assign eng_load   = (state_q == SAMPLE) && samp_done;
    assign eng_step   = (state_q == CONV);
    // The last trial bit resolves on the same edge that leaves CONV.
    assign final_code = {eng_code[ADC_BIT-1:1], comp_out};
    assign first_ch   = CH_W'(next_ch(MAX_CH'(ch_mask), MAX_CH - 1));
    assign nxt_ch     = CH_W'(next_ch(MAX_CH'(mask_q), int'(ch_sel_q)));
    assign more_ch    = (nxt_ch > ch_sel_q);
`ifdef SAR_AVG_EN
    assign acc_sum    = acc_q + ACC_W'(final_code);
`endif

    sar_bit_engine #(.ADC_BIT(ADC_BIT)) u_bit_engine (
        .clk      (clk),
        .rst      (rst),
        .load     (eng_load),
        .step     (eng_step),
        .comp_out (comp_out),
        .code     (eng_code),
        .last     (eng_last)
    );

    // Sequencer FSM with channel scan, sample timing and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            ch_sel_q     <= '0;
            samp_cnt_q   <= '0;
            sample_q     <= 1'b0;
            busy_q       <= 1'b0;
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
`ifdef SAR_AVG_EN
            acc_q        <= '0;
            pass_q       <= '0;
`endif
        end else begin
            dout_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && (|ch_mask)) begin
                        mask_q     <= ch_mask;
                        ch_sel_q   <= first_ch;
                        samp_cnt_q <= '0;
                        sample_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= SAMPLE;
`ifdef SAR_AVG_EN
                        acc_q      <= '0;
                        pass_q     <= '0;
`endif
                    end
                end
                SAMPLE: begin
                    if (samp_done) begin
                        sample_q <= 1'b0;
                        state_q  <= CONV;
                    end else begin
                        samp_cnt_q <= samp_cnt_q + 1'b1;
                    end
                end
                CONV: begin
                    if (eng_last) begin
                        state_q <= DONE;
`ifdef SAR_AVG_EN
                        acc_q <= acc_sum;
                        if (pass_q == PASS_W'(AVG_PASSES - 1)) begin
                            dout_q       <= ADC_BIT'(acc_sum >> AVG_LOG2);
                            dout_ch_q    <= ch_sel_q;
                            dout_valid_q <= 1'b1;
                        end
`else
                        dout_q       <= final_code;
                        dout_ch_q    <= ch_sel_q;
                        dout_valid_q <= 1'b1;
`endif
                    end
                end
                DONE: begin
`ifdef SAR_AVG_EN
                    if (pass_q != PASS_W'(AVG_PASSES - 1)) begin
                        // Another pass on the same channel.
                        pass_q     <= pass_q + 1'b1;
                        samp_cnt_q <= '0;
                        sample_q   <= 1'b1;
                        state_q    <= SAMPLE;
                    end else
`endif
                    if (more_ch || cont) begin
                        ch_sel_q   <= nxt_ch;
                        samp_cnt_q <= '0;
                        sample_q   <= 1'b1;
                        state_q    <= SAMPLE;
`ifdef SAR_AVG_EN
                        acc_q      <= '0;
                        pass_q     <= '0;
`endif
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sample     = sample_q;
    assign ch_sel     = ch_sel_q;
    assign dac_code   = (state_q == CONV) ? eng_code : '0;
    assign busy       = busy_q;
    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = dout_valid_q;

endmodule
